// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: decoder <-> mul/div unit bundle.
// start/op/rs_data/rt_data launch, mthi/mtlo/mt_data move-to, busy/done/hi/lo back.
interface hilo_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] mt_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_data, rt_data,
      output mthi, mtlo, mt_data,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data,
      input  mthi, mtlo, mt_data,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of hilo_muldiv_unit_if).
// Option: HILO_FAST_MULT_EN gives single-cycle multiply; divide stays iterative.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               rst_n,
   hilo_muldiv_unit_if.slave bus
);
   localparam int W = WIDTH;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [5:0]     r_cnt;
   logic           r_div;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_rs;
   logic [2*W-1:0] r_acc;
   logic           r_neg_q;
   logic           r_neg_r;
   logic           r_bzero;
   logic [W-1:0]   r_hi;
   logic [W-1:0]   r_lo;
   logic           r_done;

   logic w_cap;
   logic w_step;
   logic w_fin;
   logic w_mt;
   logic w_busy;
   logic w_last;
   logic w_fast;

   // Operand magnitudes; signedness is op[0]==0.
   logic           w_sgn;
   logic           w_rs_neg;
   logic           w_rt_neg;
   logic [W-1:0]   w_a_mag;
   logic [W-1:0]   w_b_mag;

   logic [W:0]     w_madd;
   logic [2*W-1:0] w_mul_nxt;
   logic [W:0]     w_dtop;
   logic [W:0]     w_dsub;
   logic           w_dok;
   logic [W-1:0]   w_drem;
   logic [2*W-1:0] w_div_nxt;
   logic [2*W-1:0] w_acc_nxt;

   logic [2*W-1:0] w_umag;
   logic [2*W-1:0] w_mres;
   logic [W-1:0]   w_q;
   logic [W-1:0]   w_r;
   logic [W-1:0]   w_hi_res;
   logic [W-1:0]   w_lo_res;

`ifdef HILO_FAST_MULT_EN
   logic [2*W-1:0] w_prod;
   assign w_prod = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
   assign w_fast = ~r_div;
   assign w_umag = w_fast ? w_prod : r_acc;
`else
   assign w_fast = 1'b0;
   assign w_umag = r_acc;
`endif

   assign w_last = (r_cnt == 6'(W)) | w_fast;

   always_comb begin
      w_next = r_state;
      w_cap  = 1'b0;
      w_step = 1'b0;
      w_fin  = 1'b0;
      w_mt   = 1'b0;
      w_busy = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_cap  = 1'b1;
               w_next = S_RUN;
            end else begin
               w_mt = 1'b1;
            end
         end
         S_RUN: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_fin  = 1'b1;
               w_next = S_IDLE;
            end else begin
               w_step = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   assign w_sgn    = ~bus.op[0];
   assign w_rs_neg = w_sgn & bus.rs_data[W-1];
   assign w_rt_neg = w_sgn & bus.rt_data[W-1];
   assign w_a_mag  = w_rs_neg ? -bus.rs_data : bus.rs_data;
   assign w_b_mag  = w_rt_neg ? -bus.rt_data : bus.rt_data;

   // Shift-add: low half holds the remaining multiplier bits.
   assign w_madd = {1'b0, r_acc[2*W-1:W]}
                 + (r_acc[0] ? {1'b0, r_a} : '0);
   assign w_mul_nxt = {w_madd, r_acc[W-1:1]};

   // Restoring divide: acc = {remainder, dividend/quotient}.
   assign w_dtop    = r_acc[2*W-1:W-1];
   assign w_dsub    = w_dtop - {1'b0, r_b};
   assign w_dok     = ~w_dsub[W];
   assign w_drem    = w_dok ? w_dsub[W-1:0] : w_dtop[W-1:0];
   assign w_div_nxt = {w_drem, r_acc[W-2:0], w_dok};

   assign w_acc_nxt = r_div ? w_div_nxt : w_mul_nxt;

   assign w_mres = r_neg_q ? -w_umag : w_umag;
   assign w_q = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
   assign w_r = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

   always_comb begin
      w_hi_res = w_mres[2*W-1:W];
      w_lo_res = w_mres[W-1:0];
      if (r_div) begin
         if (r_bzero) begin
            w_hi_res = r_rs;
            w_lo_res = {W{1'b1}};
         end else begin
            w_hi_res = w_r;
            w_lo_res = w_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_div   <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_rs    <= '0;
         r_acc   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_bzero <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_fin;
         if (w_cap) begin
            r_cnt   <= '0;
            r_div   <= bus.op[1];
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_rs    <= bus.rs_data;
            r_acc   <= {{W{1'b0}},
                        bus.op[1] ? w_a_mag : w_b_mag};
            r_neg_q <= w_rs_neg ^ w_rt_neg;
            r_neg_r <= w_rs_neg;
            r_bzero <= (bus.rt_data == '0);
         end
         if (w_step) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 6'd1;
         end
         if (w_fin) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
         end
         if (w_mt) begin
            if (bus.mthi) r_hi <= bus.mt_data;
            if (bus.mtlo) r_lo <= bus.mt_data;
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: random + directed scoreboard bench for hilo_muldiv_unit.
// Driver pushes expected {HI,LO} and latency; a monitor pops on every done.
module tb_hilo_muldiv_unit;
   logic clk;
   logic rst_n;

   hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

   hilo_muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [63:0] res;
      int          t0;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic        prev_done = 1'b0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on 64-bit values.
   function automatic logic [63:0] model(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sbv, q, r;
      logic [63:0] ua, ub;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      case (op)
         2'd0: return 64'(sa * sbv);
         2'd1: return ua * ub;
         2'd2: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sbv;
            r = sa % sbv;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   function automatic int lat_of(input logic [1:0] op);
`ifdef HILO_FAST_MULT_EN
      if (!op[1]) return 1;
`endif
      return 33;
   endfunction

   // Monitor: sample 1 time unit after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      #1;
      if (rst_n && bus.done) begin
`ifndef HILO_FAST_MULT_EN
         chk("done_pulse", 64'(prev_done), 64'd0);
`endif
         chk("busy_at_done", 64'(bus.busy), 64'd0);
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_done: got done at cycle %0d expected none",
                     cyc);
         end else begin
            e = sb.pop_front();
            chk("result", {bus.hi, bus.lo}, e.res);
            chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            m_hi = e.res[63:32];
            m_lo = e.res[31:0];
         end
      end
      prev_done = bus.done;
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) begin
         n_chk++;
         n_fail++;
         $display("FAIL busy_timeout: got busy=1 expected idle");
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic issue(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
      exp_t e;
      wait_idle();
      bus.start   = 1'b1;
      bus.op      = op;
      bus.rs_data = a;
      bus.rt_data = b;
      e.res = model(op, a, b);
      e.t0  = cyc + 1;
      e.lat = lat_of(op);
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_start", 64'(bus.busy), 64'd1);
   endtask

   task automatic mt(input logic h, input logic l,
                     input logic [31:0] d);
      bus.mthi    = h;
      bus.mtlo    = l;
      bus.mt_data = d;
      @(negedge clk);
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      if (h) m_hi = d;
      if (l) m_lo = d;
      chk("mt_hi", 64'(bus.hi), 64'(m_hi));
      chk("mt_lo", 64'(bus.lo), 64'(m_lo));
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] ev[5];
      ev = '{32'h0, 32'h1, 32'hFFFF_FFFF,
             32'h8000_0000, 32'h7FFF_FFFF};
      case ($urandom_range(0, 3))
         0: return ev[$urandom_range(0, 4)];
         1: return 32'($urandom_range(0, 20));
         2: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.op      = 2'd0;
      bus.rs_data = '0;
      bus.rt_data = '0;
      bus.mthi    = 1'b0;
      bus.mtlo    = 1'b0;
      bus.mt_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      mt(1'b1, 1'b0, 32'h1234_5678);
      mt(1'b0, 1'b1, 32'h9ABC_DEF0);
      mt(1'b1, 1'b1, 32'hA5A5_5A5A);

      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(2'd0, 32'hFFFF_FFFD, 32'd5);
      issue(2'd2, 32'hFFFF_FFF9, 32'd2);
      issue(2'd3, 32'd100, 32'd0);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(2'd2, 32'hFFFF_FFF0, 32'd0);
      issue(2'd2, 32'd7, 32'hFFFF_FFFE);
      drain();

      // start at edge 5 of a running DIVU must be dropped
      issue(2'd3, 32'd10, 32'd3);
      repeat (4) @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = 2'd1;
      bus.rs_data = 32'd7;
      bus.rt_data = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      repeat (40) @(negedge clk);
      chk("busy_ignored_lo", 64'(bus.lo), 64'd3);
      chk("busy_ignored_hi", 64'(bus.hi), 64'd1);

      // MTLO during RUN has no effect
      issue(2'd3, 32'd1000, 32'd7);
      bus.mtlo    = 1'b1;
      bus.mt_data = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mtlo = 1'b0;
      chk("mtlo_in_run", 64'(bus.lo), 64'(m_lo));
      drain();

      // start beats MTHI in the same cycle
      wait_idle();
      bus.mthi    = 1'b1;
      bus.mt_data = 32'hCAFE_F00D;
      issue(2'd1, 32'd6, 32'd9);
      bus.mthi = 1'b0;
      chk("start_wins_hi", 64'(bus.hi), 64'(m_hi));
      drain();

      // reset at edge 10 of a DIV aborts it
      issue(2'd2, 32'd12345, 32'd7);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      m_hi = '0;
      m_lo = '0;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_hi", 64'(bus.hi), 64'd0);
      chk("abort_lo", 64'(bus.lo), 64'd0);
      repeat (40) @(negedge clk);
      issue(2'd1, 32'd3, 32'd4);
      drain();

      for (int i = 0; i < 60; i++) begin
         issue(2'($urandom_range(0, 3)), pick(), pick());
         if (i % 10 == 9) begin
            drain();
            mt(1'($urandom), 1'($urandom), $urandom);
         end
      end
      drain();
      repeat (40) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide unit and owner of the HI/LO register pair for the MIPS datapath. Accepts MULT/MULTU/DIV/DIVU from the decoder with a start/busy/done handshake, runs an iterative radix-2 engine, and writes the 64-bit result into HI/LO. Also services MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO. The pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  launch op; accepted only when `busy`=0
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `rs_data`  in  32  multiplicand / dividend
- `rt_data`  in  32  multiplier / divisor
- `mthi`  in  1  write `mt_data` into HI
- `mtlo`  in  1  write `mt_data` into LO
- `mt_data`  in  32  MTHI/MTLO source
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse on result write
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States: IDLE, RUN. 6-bit iteration counter.
- IDLE with `start`=1: capture operands and `op`, go to RUN, set `busy`=1, clear counter.
- Signed ops take magnitudes at capture and record result signs. Iterate unsigned and apply the signs at the final edge.
- MULT/MULTU results:
  - {HI,LO} = full 64-bit product.
  - MULTU treats both operands as unsigned.
  - MULT is two's complement.
- DIV/DIVU results:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
- Division by zero: LO=0xFFFFFFFF, HI=`rs_data`, for both DIV and DIVU. Latency is unchanged.
- DIV overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Engine per RUN cycle:
  - Divide: one restoring shift-subtract step.
  - Multiply: one shift-add step on the 64-bit accumulator.
- Final edge: write HI/LO, `busy`→0, `done`→1 for one cycle, return to IDLE.
- `start` while `busy`=1: ignored, with no queueing.
- MTHI/MTLO:
  - Take effect on the edge when in IDLE and `start`=0.
  - Both may be asserted in the same cycle.
  - Ignored while `busy`=1 or when `start` is accepted in the same cycle; `start` wins.
- `hi`/`lo` hold their value between writes and do not change during RUN.

## Timing
- Reset, `rst_n`=0 at an edge: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset during RUN aborts the operation. No `done` is produced and HI/LO are cleared.
- Edge numbering: edge 0 samples `start`=1 in IDLE. `busy`=1 from after edge 0.
- Iterative latency: 32 steps on edges 1..32; sign fix and HI/LO write on edge 33.
- At edge 33: `busy`=0 and `done`=1 in the following cycle.
- Back-to-back: `start` may be sampled on the cycle `done`=1, since state is IDLE. The new op captures on that edge.
- MTHI/MTLO latency: HI/LO update at the sampling edge and are visible next cycle.
- `done` is never high for two consecutive cycles unless back-to-back ops of the 1-cycle path are issued (FAST_MULT_EN only).

## Configuration
- `HILO_FAST_MULT_EN` defined:
  - MULT/MULTU use a single-cycle 64-bit product computed from captured operands.
  - HI/LO write, `busy`→0 and `done`→1 all happen at edge 1.
  - Divide latency is unchanged (33).
- Not defined: multiply uses the iterative path, latency 33, same as divide.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `done` one cycle after edge 33 (edge 1 with `HILO_FAST_MULT_EN`).
- MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV variants:
  - 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Start-while-busy:
  - Issue DIVU 10/3, then assert `start` with MULTU 7×7 at edge 5 → ignored.
  - Expected result: LO=3, HI=1, exactly one `done` pulse.
- MTHI then MTLO:
  - MTHI 0x12345678 in IDLE, then MTLO 0x9ABCDEF0 → `hi`/`lo` read back next cycle.
  - MTLO asserted during RUN → no change.
- Reset mid-operation:
  - Drive `rst_n`=0 at edge 10 of a DIV → `busy`=0, `hi`=`lo`=0, no `done`.
  - After release, a new MULTU 3×4 → LO=12, HI=0.
